// File: rtl/button_event_arbiter_if.sv
// Event stream handshake between the button arbiter (master) and its consumer (slave).
interface button_event_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             evt_valid;
  logic [IDX_W-1:0] evt_id;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Serialises one-cycle button press pulses into an ordered event FIFO.
// Each button has a pending latch; a round-robin arbiter moves one pending
// button per cycle into the FIFO, which drains over a valid/ready handshake.
// Re-presses of a still-pending button are coalesced and flagged in overflow.
module button_event_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_btn_pulse,
  input  logic                   i_overflow_clr,
  output logic [WIDTH-1:0]       o_pending,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_overflow,
  button_event_arbiter_if.master evt_if
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = CNT_W - 1;

  // Registered state
  logic [WIDTH-1:0] r_pending;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // Combinational control
  logic             w_evt_valid;
  logic             w_can_push;
  logic             w_grant_valid;
  logic [IDX_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_grant_oh;
  logic             w_push;
  logic             w_pop;
  logic             w_coalesce;

  // Full rule looks only at the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_can_push  = (r_count < CNT_W'(DEPTH));
  assign w_evt_valid = (r_count != '0);
  assign w_pop       = w_evt_valid & evt_if.evt_ready;
  assign w_push      = w_grant_valid;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    cand          = 0;
    cand_idx      = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_grant_oh    = '0;
    if (w_can_push) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        cand     = (32'(r_last_grant) + 1 + k) % WIDTH;
        cand_idx = IDX_W'(cand);
        if (!w_grant_valid && r_pending[cand_idx]) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = cand_idx;
        end
      end
    end
    if (w_grant_valid) begin
      w_grant_oh[w_grant_idx] = 1'b1;
    end
  end

  // A press on a pending button that is not being granted is dropped.
  assign w_coalesce = |(i_btn_pulse & r_pending & ~w_grant_oh);

  // Pending latches and arbiter history; a press coinciding with its own grant
  // re-arms the latch so it becomes a second event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending    <= '0;
      r_last_grant <= IDX_W'(WIDTH - 1);
    end else begin
      r_pending <= (r_pending & ~w_grant_oh) | i_btn_pulse;
      if (w_grant_valid) begin
        r_last_grant <= w_grant_idx;
      end
    end
  end

  // Circular event FIFO; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky coalesce flag; a new coalesce wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_coalesce) begin
      r_overflow <= 1'b1;
    end else if (i_overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Occupancy never exceeds capacity.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (r_count <= CNT_W'(DEPTH));
    end
  end

  assign o_pending        = r_pending;
  assign o_fifo_count     = r_count;
  assign o_overflow       = r_overflow;
  assign evt_if.evt_valid = w_evt_valid;
  assign evt_if.evt_id    = w_evt_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: table-driven vectors plus
// hand-written multi-cycle sequences.
module tb_button_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic       ovf_clr;
  logic [3:0] pending;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks;
  int failures;

  button_event_arbiter_if #(.WIDTH(4)) evt_if ();

  button_event_arbiter #(
    .WIDTH(4),
    .DEPTH(4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_pulse   (btn),
    .i_overflow_clr(ovf_clr),
    .o_pending     (pending),
    .o_fifo_count  (fifo_count),
    .o_overflow    (overflow),
    .evt_if        (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;   // apply reset before this row
    logic [3:0] btn;
    logic       rdy;
    logic       vld;
    logic [1:0] id;
    logic [3:0] pend;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic v,
                     input logic [1:0] id, input logic [3:0] p, input logic [2:0] c);
    vec_t e;
    e.rst = r; e.btn = b; e.rdy = rd; e.vld = v; e.id = id; e.pend = p; e.cnt = c;
    e.ovf = 1'b0;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = '0;
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [1:0] id,
                             input logic [3:0] p, input logic [2:0] c, input logic o);
    check({tag, " valid"}, 32'(evt_if.evt_valid), 32'(v));
    check({tag, " id"}, 32'(evt_if.evt_id), 32'(id));
    check({tag, " pending"}, 32'(pending), 32'(p));
    check({tag, " count"}, 32'(fifo_count), 32'(c));
    check({tag, " overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    btn = '0;
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    #2;
    check_state("reset", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
    do_reset();

    // Single press of button 2: visible two edges later for one cycle.
    //   rst   btn      rdy   vld   id     pend     cnt
    add(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000, 3'd0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0100, 3'd0);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 3'd0);
    // Four simultaneous presses, then 1 and 3 continuing from last grant 3.
    add(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 3'd0);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1111, 3'd0);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b1110, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1100, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b1000, 3'd1);
    add(1'b0, 4'b1010, 1'b1, 1'b1, 2'd3, 4'b0000, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1010, 3'd0);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 3'd1);
    add(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      btn = tbl[i].btn;
      evt_if.evt_ready = tbl[i].rdy;
      check_state($sformatf("row%0d", i), tbl[i].vld, tbl[i].id, tbl[i].pend, tbl[i].cnt,
                  tbl[i].ovf);
      step();
    end
    btn = '0;

    // Backpressure: fill FIFO, hold button 0 pending, then drain.
    do_reset();
    btn = 4'b0001; step();
    btn = 4'b0010; step();
    btn = 4'b0100; step();
    btn = 4'b1000; step();
    btn = 4'b0001; step();
    btn = 4'b0000;
    check_state("full0", 1'b1, 2'd0, 4'b0001, 3'd4, 1'b0);
    step();
    check_state("full1", 1'b1, 2'd0, 4'b0001, 3'd4, 1'b0);
    evt_if.evt_ready = 1'b1;
    step();
    // First pop while full must not admit the pending push.
    check_state("drain0", 1'b1, 2'd1, 4'b0001, 3'd3, 1'b0);
    step();
    check_state("drain1", 1'b1, 2'd2, 4'b0000, 3'd3, 1'b0);
    step();
    check_state("drain2", 1'b1, 2'd3, 4'b0000, 3'd2, 1'b0);
    step();
    check_state("drain3", 1'b1, 2'd0, 4'b0000, 3'd1, 1'b0);
    step();
    check_state("drain4", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);

    // Coalesce with the FIFO full.
    do_reset();
    btn = 4'b1111; step();
    btn = 4'b0000; step(); step(); step(); step();
    check_state("pre", 1'b1, 2'd0, 4'b0000, 3'd4, 1'b0);
    btn = 4'b0010; step();
    btn = 4'b0000;
    check_state("coal0", 1'b1, 2'd0, 4'b0010, 3'd4, 1'b0);
    step(); step();
    btn = 4'b0010; step();
    btn = 4'b0000;
    check_state("coal1", 1'b1, 2'd0, 4'b0010, 3'd4, 1'b1);
    btn = 4'b0010; ovf_clr = 1'b1; step();
    btn = 4'b0000;
    check("clr_vs_set overflow", 32'(overflow), 32'd1);
    step();
    ovf_clr = 1'b0;
    check("clr overflow", 32'(overflow), 32'd0);
    check("clr pending", 32'(pending), 32'(4'b0010));

    // Same-cycle press and grant of button 2 yields two events.
    do_reset();
    evt_if.evt_ready = 1'b1;
    btn = 4'b0100; step();
    btn = 4'b0100; step();
    btn = 4'b0000;
    check_state("same0", 1'b1, 2'd2, 4'b0100, 3'd1, 1'b0);
    step();
    check_state("same1", 1'b1, 2'd2, 4'b0000, 3'd1, 1'b0);
    step();
    check_state("same2", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);

    // Asynchronous reset between edges with a partly filled FIFO.
    do_reset();
    btn = 4'b0111; step();
    btn = 4'b0000; step(); step();
    btn = 4'b1000; step();
    btn = 4'b0000;
    check_state("mid", 1'b1, 2'd0, 4'b1000, 3'd3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 2'd0, 4'b0000, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    btn = 4'b0001; step();
    btn = 4'b0000;
    check_state("post_rst0", 1'b0, 2'd0, 4'b0001, 3'd0, 1'b0);
    step();
    check_state("post_rst1", 1'b1, 2'd0, 4'b0000, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
